// File: rtl/wb_lsu_master.sv
// wb_lsu_master
//   Wishbone classic-cycle bus master for the core's load/store stage.
//   Handles one request at a time. Slaves are word-addressed and have no
//   byte selects, so byte and halfword stores are done as read-modify-write.
//   Load data is sign- or zero-extended. ERR and RTY terminations are
//   handled, and an access is aborted if the slave does not answer in time.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_*               request channel; accepted on req_valid & req_ready
//   rsp_valid/rdata/err one-cycle response pulse; there is no backpressure
//   CYC/STB/WE/ADR/DAT_O/CTI_O  Wishbone master outputs
//   DAT_I/ACK/ERR/RTY   Wishbone slave returns
module wb_lsu_master #(
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CYC,
  output logic        STB,
  output logic        WE,
  output logic [31:0] ADR,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic [2:0]  CTI_O,
  input  logic        ACK,
  input  logic        ERR,
  input  logic        RTY
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;

  state_t          state_reg;
  state_t          gap_tgt_reg;   // where GAP goes once the bus is quiet
  logic [1:0]      lane_reg;
  logic [1:0]      size_reg;
  logic            uns_reg;
  logic            we_reg;
  logic [15:0]     wdata_reg;     // sub-word store data kept for the merge
  logic [RW-1:0]   retry_reg;
  logic [TW-1:0]   timer_reg;

  logic            misalign;
  logic [31:0]     shifted;
  logic [31:0]     load_data;
  logic [31:0]     merged;
  logic            timed_out;

  assign CTI_O = 3'b000;

  assign misalign = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  // Move the addressed lane down to bit 0, then extend.
  assign shifted = DAT_I >> {lane_reg, 3'b000};

  always_comb begin
    load_data = DAT_I;
    case (size_reg)
      2'd0:    load_data = uns_reg ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = uns_reg ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = DAT_I;
    endcase
  end

  // Read-modify-write merge: each byte lane takes store data when the
  // request covers it, otherwise keeps the word just read from the slave.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       hit;
    logic [7:0] ins;
    assign hit = (size_reg == 2'd0) ? (lane_reg == LANE) :
                 (size_reg == 2'd1) ? (lane_reg[1] == LANE[1]) : 1'b0;
    assign ins = (size_reg == 2'd1 && LANE[0]) ? wdata_reg[15:8] : wdata_reg[7:0];
    assign merged[8*gi +: 8] = hit ? ins : DAT_I[8*gi +: 8];
  end

  assign timed_out = (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      gap_tgt_reg <= IDLE;
      lane_reg    <= '0;
      size_reg    <= '0;
      uns_reg     <= 1'b0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      retry_reg   <= '0;
      timer_reg   <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      CYC         <= 1'b0;
      STB         <= 1'b0;
      WE          <= 1'b0;
      ADR         <= '0;
      DAT_O       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      case (state_reg)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            lane_reg  <= req_addr[1:0];
            size_reg  <= req_size;
            uns_reg   <= req_unsigned;
            we_reg    <= req_we;
            wdata_reg <= req_wdata[15:0];
            ADR       <= {req_addr[31:2], 2'b00};
            retry_reg <= '0;
            timer_reg <= '0;
            if (misalign) begin
              // Rejected without touching the bus; stay ready.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && req_size == 2'd2) begin
              state_reg <= WR;
              req_ready <= 1'b0;
              CYC       <= 1'b1;
              STB       <= 1'b1;
              WE        <= 1'b1;
              DAT_O     <= req_wdata;
            end else begin
              state_reg <= RD;
              req_ready <= 1'b0;
              CYC       <= 1'b1;
              STB       <= 1'b1;
              WE        <= 1'b0;
            end
          end
        end

        RD, WR: begin
          if (ERR || ACK || RTY || timed_out) begin
            CYC         <= 1'b0;
            STB         <= 1'b0;
            WE          <= 1'b0;
            state_reg   <= GAP;
            gap_tgt_reg <= IDLE;
            timer_reg   <= '0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end

          // ERR outranks ACK when both arrive together.
          if (ERR) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (ACK) begin
            retry_reg <= '0;   // the write phase gets its own retry budget
            if (state_reg == RD && we_reg) begin
              DAT_O       <= merged;
              gap_tgt_reg <= WR;
            end else begin
              rsp_valid <= 1'b1;
              if (state_reg == RD) rsp_rdata <= load_data;
            end
          end else if (RTY) begin
            if (retry_reg == RW'(MAX_RETRY)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              retry_reg   <= retry_reg + 1'b1;
              gap_tgt_reg <= state_reg;
            end
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end

        GAP: begin
          // A registered slave keeps its termination up one extra cycle;
          // wait for it to clear so it is not taken as the next answer.
          if (!ACK && !ERR && !RTY) begin
            state_reg <= gap_tgt_reg;
            case (gap_tgt_reg)
              RD: begin
                CYC <= 1'b1;
                STB <= 1'b1;
                WE  <= 1'b0;
              end
              WR: begin
                CYC <= 1'b1;
                STB <= 1'b1;
                WE  <= 1'b1;
              end
              default: req_ready <= 1'b1;
            endcase
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Testbench for wb_lsu_master with a word-wide RAM slave that registers its
// terminations (ACK/RTY/ERR held one extra cycle after STB drops).
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        CYC, STB, WE;
  logic [31:0] ADR, DAT_O, DAT_I;
  logic [2:0]  CTI_O;
  logic        ACK, ERR, RTY;

  wb_lsu_master #(.TIMEOUT(64), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .DAT_O(DAT_O), .DAT_I(DAT_I),
    .CTI_O(CTI_O), .ACK(ACK), .ERR(ERR), .RTY(RTY)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic [31:0] ram [0:63];
  int          slv_mode;      // 0 normal (with rty_n retries), 1 ERR, 2 silent, 3 ACK+ERR
  int          rty_n;
  int          rty_given;
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ACK <= 1'b0; ERR <= 1'b0; RTY <= 1'b0; DAT_I <= '0; rty_given <= 0;
    end else begin
      if (bd_we) ram[bd_idx] <= bd_data;
      if (req_ready) rty_given <= 0;
      if (CYC && STB) begin
        if (!(ACK || ERR || RTY)) begin
          case (slv_mode)
            0: begin
              if (rty_given < rty_n) begin
                RTY <= 1'b1;
                rty_given <= rty_given + 1;
              end else begin
                ACK   <= 1'b1;
                DAT_I <= ram[ADR[7:2]];
                if (WE) ram[ADR[7:2]] <= DAT_O;
              end
            end
            1: ERR <= 1'b1;
            3: begin ACK <= 1'b1; ERR <= 1'b1; end
            default: ;
          endcase
        end
      end else begin
        ACK <= 1'b0; ERR <= 1'b0; RTY <= 1'b0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int   cyc_cnt = 0;
  int   starts = 0, wr_starts = 0, stb_hi = 0;
  logic stb_q = 1'b0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    stb_q   <= STB;
    if (req_ready) begin
      starts <= 0; wr_starts <= 0; stb_hi <= 0;
    end else begin
      if (STB && !stb_q) begin
        starts <= starts + 1;
        if (WE) wr_starts <= wr_starts + 1;
      end
      if (STB) stb_hi <= stb_hi + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] d; logic e; } exp_t;
  exp_t sb_q[$];
  exp_t ex;

  int n_pass = 0, n_total = 0;
  int acc_cyc;
  int cap_starts, cap_wr, cap_hi;
  logic [31:0] mdl [16:19];

  bit          got;
  logic [31:0] gd;
  logic        ge;
  int          lat;

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_idx = 6'(idx); bd_data = data; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) @(negedge clk);
    if (req_ready !== 1'b1) begin
      n_total++;
      $display("FAIL accept_wait: req_ready=%b after 100 cycles, required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc_cnt;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    got = 1'b0; gd = '0; ge = 1'b0; lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1; gd = rsp_rdata; ge = rsp_err; lat = cyc_cnt - acc_cyc;
        cap_starts = starts; cap_wr = wr_starts; cap_hi = stb_hi;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[a*8 +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return u ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    n_total++;
    if ({CYC, STB, WE, rsp_valid, rsp_err, req_ready, ADR, DAT_O, rsp_rdata, CTI_O} !== '0)
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b rv=%b re=%b rdy=%b adr=%h dat=%h rd=%h cti=%b, required all 0",
               CYC, STB, WE, rsp_valid, rsp_err, req_ready, ADR, DAT_O, rsp_rdata, CTI_O);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%b one cycle after release, required 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_word_load();
    preload(4, 32'hDEADBEEF);
    sb_q.push_back(exp_t'{d: 32'hDEADBEEF, e: 1'b0});
    issue(1'b0, 32'h10, '0, 2'd2, 1'b0);
    wait_rsp(20);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, lat} !== {1'b1, ex.d, ex.e, 32'sd2})
      $display("FAIL word_load: got=%b data=%h err=%b lat=%0d, required data=%h err=%b lat=2", got, gd, ge, lat, ex.d, ex.e);
    else n_pass++;
    n_total++;
    if (cap_starts !== 1) $display("FAIL word_load_cycles: %0d bus cycles, required 1", cap_starts);
    else n_pass++;
  endtask

  task automatic test_byte_load();
    preload(4, 32'h80FF0000);
    for (int u = 0; u < 2; u++) begin
      sb_q.push_back(exp_t'{d: (u == 0) ? 32'hFFFFFF80 : 32'h00000080, e: 1'b0});
      issue(1'b0, 32'h13, '0, 2'd0, 1'(u));
      wait_rsp(20);
      ex = sb_q.pop_front();
      n_total++;
      if ({got, gd, ge} !== {1'b1, ex.d, ex.e})
        $display("FAIL byte_load u=%0d: got=%b data=%h err=%b, required data=%h err=%b", u, got, gd, ge, ex.d, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_rmw_store();
    preload(8, 32'h11223344);
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b0});
    issue(1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0);
    wait_rsp(30);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, lat} !== {1'b1, ex.d, ex.e, 32'sd6})
      $display("FAIL rmw_half: got=%b data=%h err=%b lat=%0d, required data=%h err=%b lat=6", got, gd, ge, lat, ex.d, ex.e);
    else n_pass++;
    n_total++;
    if ({cap_starts, cap_wr} !== {32'sd2, 32'sd1})
      $display("FAIL rmw_half_cycles: cycles=%0d write_cycles=%0d, required 2 and 1", cap_starts, cap_wr);
    else n_pass++;
    n_total++;
    if (ram[8] !== 32'hABCD3344) $display("FAIL rmw_half_mem: ram=%h, required abcd3344", ram[8]);
    else n_pass++;
    // byte store into the merged word
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b0});
    issue(1'b1, 32'h21, 32'hFFFFFF5A, 2'd0, 1'b0);
    wait_rsp(30);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, ram[8]} !== {1'b1, ex.d, ex.e, 32'hABCD5A44})
      $display("FAIL rmw_byte: got=%b err=%b ram=%h, required err=0 ram=abcd5a44", got, ge, ram[8]);
    else n_pass++;
    // word store goes straight to the write phase
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b0});
    issue(1'b1, 32'h24, 32'hCAFEF00D, 2'd2, 1'b0);
    wait_rsp(30);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, ge, lat, cap_wr, cap_starts, ram[9]} !== {1'b1, ex.e, 32'sd2, 32'sd1, 32'sd1, 32'hCAFEF00D})
      $display("FAIL word_store: got=%b err=%b lat=%0d wr=%0d cycles=%0d ram=%h, required err=0 lat=2 wr=1 cycles=1 ram=cafef00d",
               got, ge, lat, cap_wr, cap_starts, ram[9]);
    else n_pass++;
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h06; sizes[0] = 2'd2;
    addrs[1] = 32'h10; sizes[1] = 2'd3;
    addrs[2] = 32'h21; sizes[2] = 2'd1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(exp_t'{d: 32'h0, e: 1'b1});
      issue(1'b0, addrs[k], '0, sizes[k], 1'b0);
      wait_rsp(10);
      ex = sb_q.pop_front();
      n_total++;
      if ({got, gd, ge, lat, cap_starts} !== {1'b1, ex.d, ex.e, 32'sd0, 32'sd0})
        $display("FAIL misalign%0d: got=%b data=%h err=%b lat=%0d cycles=%0d, required err=1 lat=0 cycles=0",
                 k, got, gd, ge, lat, cap_starts);
      else n_pass++;
    end
  endtask

  task automatic test_retry();
    preload(4, 32'h12345678);
    rty_n = 2;
    sb_q.push_back(exp_t'{d: 32'h12345678, e: 1'b0});
    issue(1'b0, 32'h10, '0, 2'd2, 1'b0);
    wait_rsp(40);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, cap_starts} !== {1'b1, ex.d, ex.e, 32'sd3})
      $display("FAIL retry_ok: got=%b data=%h err=%b cycles=%0d, required data=%h err=0 cycles=3", got, gd, ge, cap_starts, ex.d);
    else n_pass++;
    rty_n = 4;
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b1});
    issue(1'b0, 32'h10, '0, 2'd2, 1'b0);
    wait_rsp(40);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, cap_starts} !== {1'b1, ex.d, ex.e, 32'sd4})
      $display("FAIL retry_exhaust: got=%b data=%h err=%b cycles=%0d, required err=1 cycles=4", got, gd, ge, cap_starts);
    else n_pass++;
    rty_n = 0;
  endtask

  task automatic test_err();
    slv_mode = 1;
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b1});
    issue(1'b1, 32'h20, 32'h77, 2'd0, 1'b0);
    wait_rsp(30);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, cap_starts, cap_wr} !== {1'b1, ex.d, ex.e, 32'sd1, 32'sd0})
      $display("FAIL err_rmw: got=%b data=%h err=%b cycles=%0d wr=%0d, required err=1 cycles=1 wr=0", got, gd, ge, cap_starts, cap_wr);
    else n_pass++;
    slv_mode = 3;
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b1});
    issue(1'b0, 32'h10, '0, 2'd2, 1'b0);
    wait_rsp(30);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge} !== {1'b1, ex.d, ex.e})
      $display("FAIL ack_err_both: got=%b data=%h err=%b, required data=0 err=1", got, gd, ge);
    else n_pass++;
    slv_mode = 0;
  endtask

  task automatic test_timeout();
    slv_mode = 2;
    sb_q.push_back(exp_t'{d: 32'h0, e: 1'b1});
    issue(1'b0, 32'h10, '0, 2'd2, 1'b0);
    wait_rsp(200);
    ex = sb_q.pop_front();
    n_total++;
    if ({got, gd, ge, lat, cap_hi} !== {1'b1, ex.d, ex.e, 32'sd64, 32'sd64})
      $display("FAIL timeout: got=%b data=%h err=%b lat=%0d stb_cycles=%0d, required err=1 lat=64 stb_cycles=64",
               got, gd, ge, lat, cap_hi);
    else n_pass++;
    slv_mode = 0;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sz, ln;
    logic        we, u;
    int          w;
    logic [31:0] wd;
    for (int i = 16; i < 20; i++) begin
      mdl[i] = $urandom;
      preload(i, mdl[i]);
    end
    for (int k = 0; k < 12; k++) begin
      w  = 16 + int'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 2));
      ln = 2'($urandom_range(0, 3));
      if (sz == 2'd1) ln[0] = 1'b0;
      if (sz == 2'd2) ln = 2'b00;
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (we) begin
        case (sz)
          2'd0:    mdl[w][ln*8 +: 8] = wd[7:0];
          2'd1:    if (ln[1]) mdl[w][31:16] = wd[15:0]; else mdl[w][15:0] = wd[15:0];
          default: mdl[w] = wd;
        endcase
        sb_q.push_back(exp_t'{d: 32'h0, e: 1'b0});
      end else begin
        sb_q.push_back(exp_t'{d: extract(mdl[w], ln, sz, u), e: 1'b0});
      end
      issue(we, {24'h0, 6'(w), ln}, wd, sz, u);
      wait_rsp(30);
      ex = sb_q.pop_front();
      n_total++;
      if ({got, gd, ge} !== {1'b1, ex.d, ex.e})
        $display("FAIL b2b%0d we=%b sz=%0d lane=%0d: got=%b data=%h err=%b, required data=%h err=%b",
                 k, we, sz, ln, got, gd, ge, ex.d, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_rmw();
    bit saw_rsp;
    preload(10, 32'h55667788);
    issue(1'b1, 32'h28, 32'h000000AA, 2'd0, 1'b0);
    for (int i = 0; i < 20 && !(STB === 1'b1 && WE === 1'b1); i++) @(negedge clk);
    n_total++;
    if (!(STB === 1'b1 && WE === 1'b1)) $display("FAIL rst_mid_reach_write: stb=%b we=%b, required write phase", STB, WE);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({CYC, STB} !== 2'b00) $display("FAIL rst_mid_drop: cyc=%b stb=%b, required 0 0", CYC, STB);
    else n_pass++;
    saw_rsp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    n_total++;
    if ({saw_rsp, req_ready} !== 2'b01)
      $display("FAIL rst_mid_after: saw_rsp=%b req_ready=%b, required 0 and 1", saw_rsp, req_ready);
    else n_pass++;
    n_total++;
    if (ram[10] !== 32'h55667788) $display("FAIL rst_mid_mem: ram=%h, required 55667788 (no write)", ram[10]);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0;
    slv_mode = 0; rty_n = 0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_word_load();
    test_byte_load();
    test_rmw_store();
    test_misalign();
    test_retry();
    test_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
